// File: rtl/block_xfer_seq.sv
// Block-transfer (LDM/STM) sequencer: walks a register list one word access at a
// time, drives the register-file ports and a ready-handshake memory port, then writes back the base.
module block_xfer_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_load,
  input  logic             up,
  input  logic             pre,
  input  logic             wback,
  input  logic [3:0]       rn,
  input  logic [WIDTH-1:0] base,
  input  logic [15:0]      reglist,
  output logic [3:0]       ra,
  input  logic [WIDTH-1:0] rd,
  output logic             we,
  output logic [3:0]       wa,
  output logic [WIDTH-1:0] wd,
  output logic             pc_we,
  output logic [WIDTH-1:0] pc_wd,
  output logic [WIDTH-1:0] mem_addr,
  output logic             mem_we,
  output logic             mem_re,
  output logic [WIDTH-1:0] mem_wd,
  input  logic [WIDTH-1:0] mem_rd,
  input  logic             mem_ready,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_WB   = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [WIDTH-1:0] STRIDE = WIDTH'(4);

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) begin
        idx = 4'(i);
      end
    end
    return idx;
  endfunction

  state_e           state_q;
  logic [15:0]      list_q;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] final_q;
  logic             load_q;
  logic             wbeff_q;
  logic [3:0]       rn_q;

  logic [4:0]       count_s;
  logic [WIDTH-1:0] span_s;
  logic [WIDTH-1:0] first_s;
  logic [WIDTH-1:0] final_s;
  logic [3:0]       cur_s;
  logic             last_s;

  // Launch-time address arithmetic and current-register selection
  always_comb begin
    count_s = popcount16(reglist);
    span_s  = {{(WIDTH-7){1'b0}}, count_s, 2'b00};
    case ({up, pre})
      2'b10:   first_s = base;
      2'b11:   first_s = base + STRIDE;
      2'b00:   first_s = base - span_s + STRIDE;
      2'b01:   first_s = base - span_s;
      default: first_s = base;
    endcase
    if (up) begin
      final_s = base + span_s;
    end else begin
      final_s = base - span_s;
    end
    cur_s  = lowest_set(list_q);
    last_s = ((list_q & (list_q - 16'd1)) == 16'd0);
  end

  // Sequencer state; a loaded base register suppresses the writeback
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      list_q  <= 16'd0;
      addr_q  <= '0;
      final_q <= '0;
      load_q  <= 1'b0;
      wbeff_q <= 1'b0;
      rn_q    <= 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            list_q  <= reglist;
            addr_q  <= first_s;
            final_q <= final_s;
            load_q  <= is_load;
            wbeff_q <= wback && !(is_load && reglist[rn]);
            rn_q    <= rn;
            if (reglist != 16'd0) begin
              state_q <= S_XFER;
            end else if (wback) begin
              state_q <= S_WB;
            end else begin
              state_q <= S_DONE;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_XFER: begin
          if (mem_ready) begin
            list_q <= list_q & ~(16'd1 << cur_s);
            addr_q <= addr_q + STRIDE;
            if (last_s) begin
              state_q <= wbeff_q ? S_WB : S_DONE;
            end else begin
              state_q <= S_XFER;
            end
          end else begin
            state_q <= S_XFER;
          end
        end
        S_WB:    state_q <= S_DONE;
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Port decode; load writes are same-cycle so they commit on the ready edge
  always_comb begin
    ra       = 4'd0;
    we       = 1'b0;
    wa       = 4'd0;
    wd       = '0;
    pc_we    = 1'b0;
    pc_wd    = '0;
    mem_addr = '0;
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    mem_wd   = '0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_XFER: begin
        busy     = 1'b1;
        mem_addr = addr_q;
        mem_re   = load_q;
        mem_we   = !load_q;
        if (load_q) begin
          wa = cur_s;
          if (cur_s == 4'd15) begin
            pc_we = mem_ready;
            pc_wd = mem_rd;
          end else begin
            we = mem_ready;
            wd = mem_rd;
          end
        end else begin
          ra     = cur_s;
          mem_wd = rd;
        end
      end
      S_WB: begin
        busy = 1'b1;
        if (rn_q == 4'd15) begin
          pc_we = 1'b1;
          pc_wd = final_q;
        end else begin
          we = 1'b1;
          wa = rn_q;
          wd = final_q;
        end
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule
